shift_counter_gen: RTL and testbench

- Parametrised shift-register counter family. Generalises the fixed 5-bit Johnson counter to WIDTH stages.
- Adds a runtime-selectable Johnson or ring mode, direction control, clock enable and parallel load.
- Adds illegal-state detection with self-correction, decoded state index and terminal-count outputs.
- Used as a sequencer/phase generator feeding decode logic in lab datapaths.

---
 rtl/shift_counter_gen.sv | 103 ++++++++++
 tb/tb_shift_counter_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shift_counter_gen.sv
// Parametrised Johnson/ring shift counter with direction, enable, parallel load,
// illegal-state self-correction with a sticky error flag, and decoded index/terminal count.
module shift_counter_gen #(
  parameter  int WIDTH = 5,
  localparam int IW    = $clog2(2 * WIDTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic [IW-1:0]    index_o,
  output logic             tc_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic             legal;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] rst_val;
  logic [WIDTH-1:0] shifted;
  logic             fb;
  logic [IW-1:0]    last_idx;

  // Decode legality and sequence position; idx stays 0 for any illegal code.
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    if (!mode_i) begin
      for (int k = 0; k <= WIDTH; k++) begin
        if (q_q == (ONES >> (WIDTH - k))) begin
          legal = 1'b1;
          idx   = IW'(k);
        end
      end
      for (int m = 1; m < WIDTH; m++) begin
        if (q_q == (ONES << m)) begin
          legal = 1'b1;
          idx   = IW'(WIDTH + m);
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (q_q == (ONE << i)) begin
          legal = 1'b1;
          idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    rst_val = mode_i ? ONE : '0;
    if (!dir_i) begin
      fb      = mode_i ? q_q[WIDTH-1] : ~q_q[WIDTH-1];
      shifted = {q_q[WIDTH-2:0], fb};
    end else begin
      fb      = mode_i ? q_q[0] : ~q_q[0];
      shifted = {fb, q_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    if (load_i) begin
      q_d   = load_val_i;
      err_d = 1'b0;
    end else if (en_i) begin
      if (legal) begin
        q_d = shifted;
      end else begin
        q_d   = rst_val;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      q_q   <= rst_val;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign last_idx = mode_i ? IW'(WIDTH - 1) : IW'(2 * WIDTH - 1);
  assign q_o      = q_q;
  assign err_o    = err_q;
  assign index_o  = idx;
  assign tc_o     = reset_i & ~load_i & en_i & legal &
                    (dir_i ? (idx == '0) : (idx == last_idx));

endmodule

// File: tb/tb_shift_counter_gen.sv
// Scoreboard bench for shift_counter_gen at WIDTH=5: each step's expected post-edge
// state is queued when its stimulus is driven and popped once the edge has passed.
module tb_shift_counter_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [4:0] load_val = '0;
  logic [4:0] q;
  logic [3:0] index;
  logic       tc, err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rst, en, mode, dir, load;
    logic [4:0] lv;
    logic       tc;
    logic [4:0] q;
    logic [3:0] idx;
    logic       err;
  } step_t;

  step_t sb[$];
  logic [4:0] jt [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                          5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

  shift_counter_gen #(.WIDTH(5)) dut (
    .clock_i(clock), .reset_i(reset), .en_i(en), .mode_i(mode), .dir_i(dir),
    .load_i(load), .load_val_i(load_val), .q_o(q), .index_o(index),
    .tc_o(tc), .err_o(err)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(bit r, bit e, bit m, bit d, bit l, logic [4:0] lv,
                               bit t, logic [4:0] eq, int ei, bit ee);
    step_t s;
    s.rst = r; s.en = e; s.mode = m; s.dir = d; s.load = l; s.lv = lv;
    s.tc = t; s.q = eq; s.idx = 4'(ei); s.err = ee;
    return s;
  endfunction

  task automatic drive(step_t s);
    reset = s.rst; en = s.en; mode = s.mode; dir = s.dir; load = s.load; load_val = s.lv;
  endtask

  task automatic test_reset();
    step_t st[$];
    step_t e;
    st.push_back(mk(0, 1, 0, 0, 1, 5'b10101, 0, 5'b00000, 0, 0));
    st.push_back(mk(0, 0, 1, 0, 0, 5'b00000, 0, 5'b00001, 0, 0));
    st.push_back(mk(0, 1, 1, 0, 1, 5'b11111, 0, 5'b00001, 0, 0));
    st.push_back(mk(0, 1, 0, 1, 1, 5'b01010, 0, 5'b00000, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(st[i]); #1;
      n_checks++; if (tc !== st[i].tc) $display("FAIL reset tc step %0d: got %b want %b", i, tc, st[i].tc); else n_pass++;
      @(posedge clock); #1; e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL reset q step %0d: got %b want %b", i, q, e.q); else n_pass++;
      n_checks++; if (index !== e.idx) $display("FAIL reset index step %0d: got %0d want %0d", i, index, e.idx); else n_pass++;
      n_checks++; if (err !== e.err) $display("FAIL reset err step %0d: got %b want %b", i, err, e.err); else n_pass++;
    end
  endtask

  task automatic test_johnson();
    step_t st[$];
    step_t e;
    st.push_back(mk(0, 0, 0, 0, 0, 5'b0, 0, 5'b00000, 0, 0));
    for (int i = 0; i < 10; i++)
      st.push_back(mk(1, 1, 0, 0, 0, 5'b0, i == 9, jt[(i + 1) % 10], (i + 1) % 10, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 5'b0, 0, 5'b00000, 0, 0));
    st.push_back(mk(0, 1, 0, 1, 0, 5'b0, 0, 5'b00000, 0, 0));
    for (int s = 1; s <= 3; s++)
      st.push_back(mk(1, 1, 0, 1, 0, 5'b0, s == 1, jt[(10 - s) % 10], (10 - s) % 10, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(st[i]); #1;
      n_checks++; if (tc !== st[i].tc) $display("FAIL johnson tc step %0d: got %b want %b", i, tc, st[i].tc); else n_pass++;
      @(posedge clock); #1; e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL johnson q step %0d: got %b want %b", i, q, e.q); else n_pass++;
      n_checks++; if (index !== e.idx) $display("FAIL johnson index step %0d: got %0d want %0d", i, index, e.idx); else n_pass++;
      n_checks++; if (err !== e.err) $display("FAIL johnson err step %0d: got %b want %b", i, err, e.err); else n_pass++;
    end
  endtask

  task automatic test_ring();
    step_t st[$];
    step_t e;
    st.push_back(mk(0, 0, 1, 0, 0, 5'b0, 0, 5'b00001, 0, 0));
    for (int i = 0; i < 5; i++)
      st.push_back(mk(1, 1, 1, 0, 0, 5'b0, i == 4, 5'(1 << ((i + 1) % 5)), (i + 1) % 5, 0));
    st.push_back(mk(1, 1, 1, 1, 0, 5'b0, 1, 5'b10000, 4, 0));
    st.push_back(mk(1, 1, 1, 1, 0, 5'b0, 0, 5'b01000, 3, 0));
    st.push_back(mk(1, 0, 1, 1, 0, 5'b0, 0, 5'b01000, 3, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(st[i]); #1;
      n_checks++; if (tc !== st[i].tc) $display("FAIL ring tc step %0d: got %b want %b", i, tc, st[i].tc); else n_pass++;
      @(posedge clock); #1; e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL ring q step %0d: got %b want %b", i, q, e.q); else n_pass++;
      n_checks++; if (index !== e.idx) $display("FAIL ring index step %0d: got %0d want %0d", i, index, e.idx); else n_pass++;
      n_checks++; if (err !== e.err) $display("FAIL ring err step %0d: got %b want %b", i, err, e.err); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    step_t st[$];
    step_t e;
    st.push_back(mk(1, 0, 0, 0, 1, 5'b00101, 0, 5'b00101, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 5'b00000, 0, 1));
    for (int s = 1; s <= 20; s++)
      st.push_back(mk(1, 1, 0, 0, 0, 5'b0, ((s - 1) % 10) == 9, jt[s % 10], s % 10, 1));
    st.push_back(mk(1, 1, 0, 0, 1, 5'b00011, 0, 5'b00011, 2, 0));
    st.push_back(mk(1, 0, 0, 0, 1, 5'b00110, 0, 5'b00110, 0, 0));
    for (int s = 0; s < 5; s++)
      st.push_back(mk(1, 0, 0, 0, 0, 5'b0, 0, 5'b00110, 0, 0));
    st.push_back(mk(1, 1, 0, 1, 0, 5'b0, 0, 5'b00000, 0, 1));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(st[i]); #1;
      n_checks++; if (tc !== st[i].tc) $display("FAIL illegal tc step %0d: got %b want %b", i, tc, st[i].tc); else n_pass++;
      @(posedge clock); #1; e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL illegal q step %0d: got %b want %b", i, q, e.q); else n_pass++;
      n_checks++; if (index !== e.idx) $display("FAIL illegal index step %0d: got %0d want %0d", i, index, e.idx); else n_pass++;
      n_checks++; if (err !== e.err) $display("FAIL illegal err step %0d: got %b want %b", i, err, e.err); else n_pass++;
    end
  endtask

  task automatic test_mode_switch();
    step_t st[$];
    step_t e;
    st.push_back(mk(0, 0, 0, 0, 0, 5'b0, 0, 5'b00000, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 5'b00001, 1, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 5'b00011, 2, 0));
    st.push_back(mk(1, 1, 1, 0, 0, 5'b0, 0, 5'b00001, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 5'b0, 0, 5'b00000, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 5'b00001, 1, 0));
    st.push_back(mk(1, 1, 1, 0, 0, 5'b0, 0, 5'b00010, 1, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 5'b00000, 0, 1));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(st[i]); #1;
      n_checks++; if (tc !== st[i].tc) $display("FAIL mode_switch tc step %0d: got %b want %b", i, tc, st[i].tc); else n_pass++;
      @(posedge clock); #1; e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL mode_switch q step %0d: got %b want %b", i, q, e.q); else n_pass++;
      n_checks++; if (index !== e.idx) $display("FAIL mode_switch index step %0d: got %0d want %0d", i, index, e.idx); else n_pass++;
      n_checks++; if (err !== e.err) $display("FAIL mode_switch err step %0d: got %b want %b", i, err, e.err); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    step_t e;
    st.push_back(mk(1, 1, 0, 0, 1, 5'b01111, 0, 5'b01111, 4, 0));
    st.push_back(mk(1, 1, 0, 0, 1, 5'b11000, 0, 5'b11000, 8, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 5'b0, 0, 5'b10000, 9, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 5'b0, 1, 5'b00000, 0, 0));
    st.push_back(mk(1, 1, 1, 0, 1, 5'b10000, 0, 5'b10000, 4, 0));
    st.push_back(mk(1, 1, 1, 0, 0, 5'b0, 1, 5'b00001, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(st[i]); #1;
      n_checks++; if (tc !== st[i].tc) $display("FAIL back_to_back tc step %0d: got %b want %b", i, tc, st[i].tc); else n_pass++;
      @(posedge clock); #1; e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL back_to_back q step %0d: got %b want %b", i, q, e.q); else n_pass++;
      n_checks++; if (index !== e.idx) $display("FAIL back_to_back index step %0d: got %0d want %0d", i, index, e.idx); else n_pass++;
      n_checks++; if (err !== e.err) $display("FAIL back_to_back err step %0d: got %b want %b", i, err, e.err); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_johnson();
    test_ring();
    test_illegal();
    test_mode_switch();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard residue: got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
